// File: rtl/sprite_draw_sequencer.sv
// Feeds sprite bytes from the host command path to sprite_engine one draw at a time,
// chaining the cursor between bytes and wrapping it at the 640x400 framebuffer edges.
module sprite_draw_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic       set_cursor_valid_in,
  input  logic [9:0] set_cursor_x_in,
  input  logic [9:0] set_cursor_y_in,
  input  logic [9:0] draw_width_in,
  input  logic [1:0] color_mode_in,
  input  logic [3:0] color_pallet_offset_in,
  input  logic       sprite_begin_in,
  input  logic       sprite_end_in,
  input  logic       data_valid_in,
  input  logic [7:0] data_in,
  output logic       data_ready_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       error_out,
  output logic [9:0] cursor_x_out,
  output logic [9:0] cursor_y_out,
  output logic       sprite_draw_enable_out,
  output logic       sprite_draw_data_valid_out,
  output logic [7:0] sprite_draw_data_out,
  output logic [9:0] cursor_start_x_position_out,
  output logic [9:0] cursor_start_y_position_out,
  output logic [9:0] draw_width_out,
  output logic [1:0] color_mode_out,
  output logic [3:0] color_pallet_offset_out,
  input  logic       cursor_end_position_valid_in,
  input  logic [9:0] cursor_end_x_position_in,
  input  logic [9:0] cursor_end_y_position_in
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StStrobe, StGap, StDone} state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              open_q, open_d, gap_q, gap_d;
  logic              ready_q, ready_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic              enable_q, enable_d, dvalid_q, dvalid_d;
  logic [7:0]        data_q, data_d;
  logic [9:0]        cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [9:0]        start_x_q, start_x_d, start_y_q, start_y_d;
  logic [9:0]        width_q, width_d;
  logic [1:0]        mode_q, mode_d;
  logic [3:0]        pal_q, pal_d;
  logic              push, pop, flush;

  // Engine-returned cursor folded back into the framebuffer.
  logic        wrap_carry;
  logic [9:0]  wrap_x, wrap_y;
  logic [10:0] wrap_y11;
  assign wrap_carry = cursor_end_x_position_in >= 10'd640;
  assign wrap_x     = wrap_carry ? cursor_end_x_position_in - 10'd640 : cursor_end_x_position_in;
  assign wrap_y11   = {1'b0, cursor_end_y_position_in} + {10'd0, wrap_carry};
  assign wrap_y     = (wrap_y11 >= 11'd400) ? 10'd0 : wrap_y11[9:0];

  always_comb begin
    state_d   = state_q;
    open_d    = open_q;
    gap_d     = gap_q;
    tmo_d     = tmo_q;
    busy_d    = busy_q;
    enable_d  = enable_q;
    dvalid_d  = dvalid_q;
    data_d    = data_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    start_x_d = start_x_q;
    start_y_d = start_y_q;
    width_d   = width_q;
    mode_d    = mode_q;
    pal_d     = pal_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    push      = data_valid_in && ready_q;

    case (state_q)
      StIdle: begin
        if (set_cursor_valid_in) begin
          cur_x_d = set_cursor_x_in;
          cur_y_d = set_cursor_y_in;
        end
        if (sprite_begin_in) begin
          width_d  = draw_width_in;
          mode_d   = color_mode_in;
          pal_d    = color_pallet_offset_in;
          open_d   = 1'b1;
          busy_d   = 1'b1;
          enable_d = 1'b1;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          data_d    = mem[rd_ptr_q];
          start_x_d = cur_x_q;
          start_y_d = cur_y_q;
          dvalid_d  = 1'b1;
          tmo_d     = '0;
          state_d   = StStrobe;
        end else if (!open_q) begin
          state_d = StDone;
        end
      end
      StStrobe: begin
        if (cursor_end_position_valid_in) begin
          cur_x_d  = wrap_x;
          cur_y_d  = wrap_y;
          dvalid_d = 1'b0;
          gap_d    = 1'b0;
          state_d  = StGap;
        end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          error_d  = 1'b1;
          flush    = 1'b1;
          open_d   = 1'b0;
          dvalid_d = 1'b0;
          state_d  = StDone;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StGap: begin
        // Two low cycles so the engine's edge detector re-arms.
        if (gap_q) state_d = StLoad;
        else       gap_d   = 1'b1;
      end
      StDone: begin
        done_d   = 1'b1;
        busy_d   = 1'b0;
        enable_d = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (sprite_end_in) open_d = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PtrW'(push);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      count_d  = count_q + CntW'(push) - CntW'(pop);
    end
    ready_d = open_d && (count_d != CntW'(FIFO_DEPTH));
  end

  always_ff @(posedge clock_in) begin
    if (push && !flush) mem[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tmo_q     <= '0;
      open_q    <= 1'b0;
      gap_q     <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      enable_q  <= 1'b0;
      dvalid_q  <= 1'b0;
      data_q    <= '0;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      start_x_q <= '0;
      start_y_q <= '0;
      width_q   <= '0;
      mode_q    <= '0;
      pal_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tmo_q     <= tmo_d;
      open_q    <= open_d;
      gap_q     <= gap_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      enable_q  <= enable_d;
      dvalid_q  <= dvalid_d;
      data_q    <= data_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      start_x_q <= start_x_d;
      start_y_q <= start_y_d;
      width_q   <= width_d;
      mode_q    <= mode_d;
      pal_q     <= pal_d;
    end
  end

  assign data_ready_out              = ready_q;
  assign busy_out                    = busy_q;
  assign done_out                    = done_q;
  assign error_out                   = error_q;
  assign cursor_x_out                = cur_x_q;
  assign cursor_y_out                = cur_y_q;
  assign sprite_draw_enable_out      = enable_q;
  assign sprite_draw_data_valid_out  = dvalid_q;
  assign sprite_draw_data_out        = data_q;
  assign cursor_start_x_position_out = start_x_q;
  assign cursor_start_y_position_out = start_y_q;
  assign draw_width_out              = width_q;
  assign color_mode_out              = mode_q;
  assign color_pallet_offset_out     = pal_q;

endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// Directed bench for sprite_draw_sequencer: single byte, chaining, FIFO fill, wrap,
// timeout with flush, empty sprite, busy-time command rejection and mid-sprite reset.
module tb_sprite_draw_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       set_valid;
  logic [9:0] set_x, set_y, width;
  logic [1:0] mode;
  logic [3:0] pal;
  logic       sbegin, send, dvalid_in;
  logic [7:0] din;
  logic       ready, busy, done, error;
  logic [9:0] cur_x, cur_y;
  logic       enable, dvalid;
  logic [7:0] dout;
  logic [9:0] start_x, start_y, width_o;
  logic [1:0] mode_o;
  logic [3:0] pal_o;
  logic       end_valid;
  logic [9:0] end_x, end_y;

  int total = 0;
  int bad   = 0;
  int cyc = 0, rise_cyc = 0, err_cyc = 0, done_cnt = 0, rise_cnt = 0;
  logic dv_prev = 1'b0;

  sprite_draw_sequencer dut (
    .clock_in                    (clk),
    .reset_in                    (rst),
    .set_cursor_valid_in         (set_valid),
    .set_cursor_x_in             (set_x),
    .set_cursor_y_in             (set_y),
    .draw_width_in               (width),
    .color_mode_in               (mode),
    .color_pallet_offset_in      (pal),
    .sprite_begin_in             (sbegin),
    .sprite_end_in               (send),
    .data_valid_in               (dvalid_in),
    .data_in                     (din),
    .data_ready_out              (ready),
    .busy_out                    (busy),
    .done_out                    (done),
    .error_out                   (error),
    .cursor_x_out                (cur_x),
    .cursor_y_out                (cur_y),
    .sprite_draw_enable_out      (enable),
    .sprite_draw_data_valid_out  (dvalid),
    .sprite_draw_data_out        (dout),
    .cursor_start_x_position_out (start_x),
    .cursor_start_y_position_out (start_y),
    .draw_width_out              (width_o),
    .color_mode_out              (mode_o),
    .color_pallet_offset_out     (pal_o),
    .cursor_end_position_valid_in(end_valid),
    .cursor_end_x_position_in    (end_x),
    .cursor_end_y_position_in    (end_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dvalid && !dv_prev) begin
      rise_cyc <= cyc;
      rise_cnt <= rise_cnt + 1;
    end
    if (error) err_cyc <= cyc;
    if (done) done_cnt <= done_cnt + 1;
    dv_prev <= dvalid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_sprite(input logic [9:0] x, input logic [9:0] y, input logic [9:0] w,
                              input logic [1:0] m, input logic [3:0] p);
    set_valid = 1'b1; set_x = x; set_y = y;
    sbegin = 1'b1; width = w; mode = m; pal = p;
    tick();
    set_valid = 1'b0; sbegin = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    dvalid_in = 1'b1; din = b;
    tick();
    dvalid_in = 1'b0;
  endtask

  task automatic end_sprite();
    send = 1'b1;
    tick();
    send = 1'b0;
  endtask

  // Acts as the engine for one byte: waits for the strobe, checks it, answers.
  task automatic engine_byte(input logic [7:0] exp_data, input logic [9:0] sx,
                             input logic [9:0] sy, input logic [9:0] rx, input logic [9:0] ry,
                             input logic [9:0] cx, input logic [9:0] cy, input bit chk_gap);
    int  waited = 0;
    bit  seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (dvalid) begin
        seen = 1'b1;
        break;
      end
      tick();
      waited++;
    end
    check("strobe_seen", 32'(seen), 32'd1);
    if (chk_gap) check("gap_low_cycles_ge3", 32'(waited >= 3), 32'd1);
    check("strobe_data", 32'(dout), 32'(exp_data));
    check("start_x", 32'(start_x), 32'(sx));
    check("start_y", 32'(start_y), 32'(sy));
    end_valid = 1'b1; end_x = rx; end_y = ry;
    tick();
    end_valid = 1'b0;
    check("strobe_low_after_end", 32'(dvalid), 32'd0);
    check("cursor_x_after", 32'(cur_x), 32'(cx));
    check("cursor_y_after", 32'(cur_y), 32'(cy));
  endtask

  task automatic wait_done();
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("done_seen", 32'(found), 32'd1);
  endtask

  initial begin
    int dc, rc;
    rst = 1'b1; set_valid = 1'b0; set_x = '0; set_y = '0; width = '0; mode = '0; pal = '0;
    sbegin = 1'b0; send = 1'b0; dvalid_in = 1'b0; din = '0;
    end_valid = 1'b0; end_x = '0; end_y = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_dvalid", 32'(dvalid), 32'd0);
    check("rst_cursor", 32'({cur_x, cur_y}), 32'd0);
    check("rst_done_error", 32'({done, error}), 32'd0);

    // Single byte.
    set_valid = 1'b1; set_x = 10'd10; set_y = 10'd20;
    tick();
    set_valid = 1'b0;
    check("set_cursor_x", 32'(cur_x), 32'd10);
    check("set_cursor_y", 32'(cur_y), 32'd20);
    sbegin = 1'b1; width = 10'd8; mode = 2'b00; pal = 4'h0;
    tick();
    sbegin = 1'b0;
    check("begin_busy", 32'(busy), 32'd1);
    check("begin_enable", 32'(enable), 32'd1);
    check("begin_ready", 32'(ready), 32'd1);
    dc = done_cnt;
    push(8'h5A);
    end_sprite();
    engine_byte(8'h5A, 10'd10, 10'd20, 10'd18, 10'd20, 10'd18, 10'd20, 1'b0);
    wait_done();
    check("single_busy_low", 32'(busy), 32'd0);
    check("single_enable_low", 32'(enable), 32'd0);
    tick();
    check("single_done_pulse", 32'(done), 32'd0);
    check("single_done_count", 32'(done_cnt - dc), 32'd1);

    // Cursor chaining, cursor load and begin in the same cycle.
    begin_sprite(10'd10, 10'd20, 10'd8, 2'b01, 4'h3);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    end_sprite();
    engine_byte(8'h11, 10'd10, 10'd20, 10'd18, 10'd20, 10'd18, 10'd20, 1'b0);
    engine_byte(8'h22, 10'd18, 10'd20, 10'd26, 10'd20, 10'd26, 10'd20, 1'b1);
    engine_byte(8'h33, 10'd26, 10'd20, 10'd34, 10'd20, 10'd34, 10'd20, 1'b1);
    wait_done();
    tick();

    // FIFO fill: first byte moves into the strobe, then 16 more fill the FIFO.
    begin_sprite(10'd0, 10'd0, 10'd8, 2'b00, 4'h0);
    rc = rise_cnt;
    for (int i = 0; i < 17; i++) begin
      dvalid_in = 1'b1; din = 8'(8'h80 + i);
      tick();
      if (i == 15) check("ready_before_full", 32'(ready), 32'd1);
      if (i == 16) check("ready_after_full", 32'(ready), 32'd0);
    end
    din = 8'hEE;
    tick();
    dvalid_in = 1'b0;
    end_sprite();
    for (int i = 0; i < 17; i++) begin
      engine_byte(8'(8'h80 + i), 10'(8 * i), 10'd0, 10'(8 * (i + 1)), 10'd0,
                  10'(8 * (i + 1)), 10'd0, i > 0);
    end
    wait_done();
    check("fifo_strobe_count", 32'(rise_cnt - rc), 32'd17);
    check("fifo_cursor_x", 32'(cur_x), 32'd136);
    tick();

    // Wrap at both edges.
    begin_sprite(10'd636, 10'd399, 10'd8, 2'b10, 4'h5);
    push(8'h77);
    end_sprite();
    engine_byte(8'h77, 10'd636, 10'd399, 10'd644, 10'd399, 10'd4, 10'd0, 1'b0);
    check("cfg_width", 32'(width_o), 32'd8);
    check("cfg_mode", 32'(mode_o), 32'd2);
    check("cfg_pal", 32'(pal_o), 32'd5);
    wait_done();
    tick();

    // Timeout with bytes still queued.
    begin_sprite(10'd100, 10'd50, 10'd8, 2'b00, 4'h0);
    push(8'h42);
    push(8'h43);
    push(8'h44);
    end_sprite();
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (error) begin
          seen = 1'b1;
          break;
        end
        tick();
      end
      check("timeout_error_seen", 32'(seen), 32'd1);
    end
    tick();
    check("timeout_latency", 32'(err_cyc - rise_cyc), 32'd64);
    check("timeout_error_pulse", 32'(error), 32'd0);
    check("timeout_done", 32'(done), 32'd1);
    check("timeout_busy_low", 32'(busy), 32'd0);
    check("timeout_ready_low", 32'(ready), 32'd0);
    check("timeout_cursor_kept", 32'({cur_x, cur_y}), 32'({10'd100, 10'd50}));
    tick();
    // Queued 0x43/0x44 must be gone: the next sprite draws only its own byte.
    sbegin = 1'b1;
    tick();
    sbegin = 1'b0;
    push(8'h99);
    end_sprite();
    engine_byte(8'h99, 10'd100, 10'd50, 10'd108, 10'd50, 10'd108, 10'd50, 1'b0);
    wait_done();
    tick();

    // Empty sprite: begin and end together.
    rc = rise_cnt;
    dc = done_cnt;
    sbegin = 1'b1; send = 1'b1;
    tick();
    sbegin = 1'b0; send = 1'b0;
    wait_done();
    tick();
    check("empty_no_strobe", 32'(rise_cnt - rc), 32'd0);
    check("empty_one_done", 32'(done_cnt - dc), 32'd1);

    // Busy-time commands ignored, then reset mid-strobe.
    begin_sprite(10'd200, 10'd100, 10'd12, 2'b01, 4'h1);
    push(8'h10);
    set_valid = 1'b1; set_x = 10'd5; set_y = 10'd5;
    sbegin = 1'b1; width = 10'd3;
    tick();
    set_valid = 1'b0; sbegin = 1'b0;
    check("busy_set_ignored", 32'({cur_x, cur_y}), 32'({10'd200, 10'd100}));
    repeat (3) tick();
    check("busy_strobe_up", 32'(dvalid), 32'd1);
    check("busy_begin_ignored", 32'(width_o), 32'd12);
    dc = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_enable_dvalid", 32'({enable, dvalid}), 32'd0);
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_cursor", 32'({cur_x, cur_y}), 32'd0);
    check("midrst_engine_bus", 32'({dout, start_x, start_y}), 32'd0);
    check("midrst_cfg", 32'({width_o, mode_o, pal_o}), 32'd0);
    repeat (6) tick();
    check("midrst_no_done", 32'(done_cnt - dc), 32'd0);
    check("midrst_idle_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
